// File: rtl/kalman_step_sequencer.sv
// Kalman filter step sequencer: prediction -> gain -> update per accepted sample tick.
// Buffers one early tick, counts dropped ticks, and supervises each datapath wait
// with a ready-blanking window and a timeout. All progress is gated by clk_en.
module kalman_step_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned USE_GAIN       = 1,
  parameter int unsigned CNT_WIDTH      = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clk_en,
  input  logic                 run,
  input  logic                 sample_tick,
  input  logic                 clear_err,
  input  logic                 ready_Prediction,
  input  logic                 ready_Gain,
  input  logic                 ready_Update,
  output logic                 Start_Prediction,
  output logic                 Start_Gain,
  output logic                 Start_Update,
  output logic                 busy,
  output logic                 step_done,
  output logic [CNT_WIDTH-1:0] step_count,
  output logic [7:0]           overrun_count,
  output logic                 error,
  output logic [2:0]           dbg_state
);

  localparam int unsigned WCW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(TIMEOUT_CYCLES - 1);
  localparam bit GAIN_EN = (USE_GAIN != 0);

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_PRED_START = 3'd1;
  localparam logic [2:0] S_PRED_WAIT  = 3'd2;
  localparam logic [2:0] S_GAIN_START = 3'd3;
  localparam logic [2:0] S_GAIN_WAIT  = 3'd4;
  localparam logic [2:0] S_UPD_START  = 3'd5;
  localparam logic [2:0] S_UPD_WAIT   = 3'd6;
  localparam logic [2:0] S_ERROR      = 3'd7;

  logic [2:0]           r_state;
  logic                 r_pending;
  logic [WCW-1:0]       r_wait_cnt;
  logic                 r_start_pred;
  logic                 r_start_gain;
  logic                 r_start_upd;
  logic                 r_busy;
  logic                 r_error;
  logic                 r_step_done;
  logic [CNT_WIDTH-1:0] r_step_count;
  logic [7:0]           r_overrun;

  logic [2:0]     w_state_nxt;
  logic           w_pending_nxt;
  logic [WCW-1:0] w_wait_cnt_nxt;
  logic           w_ovr_inc;
  logic           w_step_fin;
  logic           w_tick;
  logic           w_ready_ok;
  logic           w_timeout;
  logic           w_busy_state;

  assign w_tick       = run & sample_tick;
  assign w_ready_ok   = (r_wait_cnt != '0);
  assign w_timeout    = (r_wait_cnt == WAIT_LAST);
  assign w_busy_state = (r_state != S_IDLE) && (r_state != S_ERROR);

  // Next-state, pending-tick and wait-counter logic
  always_comb begin
    w_state_nxt    = r_state;
    w_pending_nxt  = r_pending;
    w_wait_cnt_nxt = r_wait_cnt;
    w_ovr_inc      = 1'b0;
    w_step_fin     = 1'b0;

    if (w_busy_state && w_tick) begin
      if (r_pending) begin
        w_ovr_inc = 1'b1;
      end else begin
        w_pending_nxt = 1'b1;
      end
    end

    case (r_state)
      S_IDLE: begin
        if (run && (sample_tick || r_pending)) begin
          w_state_nxt   = S_PRED_START;
          w_pending_nxt = 1'b0;
        end
      end
      S_PRED_START: begin
        w_state_nxt    = S_PRED_WAIT;
        w_wait_cnt_nxt = '0;
      end
      S_PRED_WAIT: begin
        if (w_ready_ok && ready_Prediction) begin
          w_state_nxt = GAIN_EN ? S_GAIN_START : S_UPD_START;
        end else if (w_timeout) begin
          w_state_nxt = S_ERROR;
        end else begin
          w_wait_cnt_nxt = r_wait_cnt + WCW'(1);
        end
      end
      S_GAIN_START: begin
        w_state_nxt    = S_GAIN_WAIT;
        w_wait_cnt_nxt = '0;
      end
      S_GAIN_WAIT: begin
        if (w_ready_ok && ready_Gain) begin
          w_state_nxt = S_UPD_START;
        end else if (w_timeout) begin
          w_state_nxt = S_ERROR;
        end else begin
          w_wait_cnt_nxt = r_wait_cnt + WCW'(1);
        end
      end
      S_UPD_START: begin
        w_state_nxt    = S_UPD_WAIT;
        w_wait_cnt_nxt = '0;
      end
      S_UPD_WAIT: begin
        if (w_ready_ok && ready_Update) begin
          w_step_fin = 1'b1;
          // A buffered or same-cycle tick chains straight into the next step
          if (run && (r_pending || sample_tick)) begin
            w_state_nxt   = S_PRED_START;
            w_pending_nxt = 1'b0;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else if (w_timeout) begin
          w_state_nxt = S_ERROR;
        end else begin
          w_wait_cnt_nxt = r_wait_cnt + WCW'(1);
        end
      end
      S_ERROR: begin
        w_pending_nxt = 1'b0;
        if (clear_err) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    if (w_state_nxt == S_ERROR) begin
      w_pending_nxt = 1'b0;
    end
  end

  // Sequencer state, tick buffer and wait counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_pending  <= 1'b0;
      r_wait_cnt <= '0;
    end else if (clk_en) begin
      r_state    <= w_state_nxt;
      r_pending  <= w_pending_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
    end
  end

  // Registered state decodes, kept aligned with r_state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_start_pred <= 1'b0;
      r_start_gain <= 1'b0;
      r_start_upd  <= 1'b0;
      r_busy       <= 1'b0;
      r_error      <= 1'b0;
    end else if (clk_en) begin
      r_start_pred <= (w_state_nxt == S_PRED_START);
      r_start_gain <= (w_state_nxt == S_GAIN_START);
      r_start_upd  <= (w_state_nxt == S_UPD_START);
      r_busy       <= (w_state_nxt != S_IDLE) && (w_state_nxt != S_ERROR);
      r_error      <= (w_state_nxt == S_ERROR);
    end
  end

  // Step completion pulse, step counter and saturating overrun counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_step_done  <= 1'b0;
      r_step_count <= '0;
      r_overrun    <= '0;
    end else if (clk_en) begin
      r_step_done <= w_step_fin;
      if (w_step_fin) begin
        r_step_count <= r_step_count + CNT_WIDTH'(1);
      end
      if (w_ovr_inc && (r_overrun != 8'hFF)) begin
        r_overrun <= r_overrun + 8'd1;
      end
    end
  end

  assign Start_Prediction = r_start_pred;
  assign Start_Gain       = r_start_gain;
  assign Start_Update     = r_start_upd;
  assign busy             = r_busy;
  assign error            = r_error;
  assign step_done        = r_step_done;
  assign step_count       = r_step_count;
  assign overrun_count    = r_overrun;
  assign dbg_state        = r_state;

endmodule
